// File: rtl/eth_multi_capture_ctrl.sv
// eth_multi_capture_ctrl: N-channel RX byte capture FIFOs with shared read port and run-length TX mode sequencer.
module eth_multi_capture_ctrl #(
    parameter int NCH  = 2,
    parameter int AW   = 7,
    parameter int SYNC = 2,
    parameter int CW   = 32
) (
    input  logic                  clk_200,
    input  logic                  reset_n,
    input  logic [NCH-1:0]        rx_toggle_i,
    input  logic [8*NCH-1:0]      rx_data_i,
    input  logic [NCH-1:0]        clr_i,
    input  logic [2:0]            rd_ch_i,
    input  logic                  rd_en_i,
    output logic [7:0]            rd_data_o,
    output logic                  rd_valid_o,
    output logic [(AW+1)*NCH-1:0] fill_o,
    output logic [NCH-1:0]        ovf_o,
    input  logic                  start_n_i,
    input  logic [2:0]            run_ch_i,
    input  logic [CW-1:0]         run_len_i,
    output logic [2*NCH-1:0]      mode_o,
    output logic                  busy_o
);
    localparam int DEPTH = 1 << AW;
    localparam logic [3:0] NCH4 = 4'(NCH);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    logic [NCH-1:0][SYNC-1:0] sync_q;
    logic [NCH-1:0]           hist_q, ovf_q, ev, wr, rd_hit;
    logic [NCH-1:0][AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [NCH-1:0][AW:0]     fill_q;
    logic [7:0]               mem_q [NCH][DEPTH];
    logic [7:0]               rd_byte, rd_data_q;
    logic                     rd_valid_q;
    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [2:0]               ch_q, ch_d;

    // A full FIFO still accepts a write when the same cycle drains one byte.
    always_comb begin
        ev = '0;
        wr = '0;
        rd_hit = '0;
        rd_byte = '0;
        for (int k = 0; k < NCH; k++) begin
            ev[k] = sync_q[k][SYNC-1] ^ hist_q[k];
            if (rd_ch_i == 3'(k)) begin
                rd_hit[k] = rd_en_i && (fill_q[k] != '0) && !clr_i[k];
                rd_byte = mem_q[k][rd_ptr_q[k]];
            end
            wr[k] = ev[k] && (!fill_q[k][AW] || rd_hit[k]) && !clr_i[k];
        end
    end

    always_ff @(posedge clk_200 or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            hist_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q <= '0;
            ovf_q <= '0;
            rd_data_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= |rd_hit;
            if (|rd_hit) rd_data_q <= rd_byte;
            for (int k = 0; k < NCH; k++) begin
                sync_q[k] <= SYNC'({sync_q[k], rx_toggle_i[k]});
                hist_q[k] <= sync_q[k][SYNC-1];
                if (clr_i[k]) begin
                    wr_ptr_q[k] <= '0;
                    rd_ptr_q[k] <= '0;
                    fill_q[k] <= '0;
                    ovf_q[k] <= 1'b0;
                end else begin
                    if (wr[k]) wr_ptr_q[k] <= wr_ptr_q[k] + 1'b1;
                    if (rd_hit[k]) rd_ptr_q[k] <= rd_ptr_q[k] + 1'b1;
                    fill_q[k] <= fill_q[k] + (AW+1)'(wr[k]) - (AW+1)'(rd_hit[k]);
                    if (ev[k] && !wr[k]) ovf_q[k] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_200) begin
        for (int k = 0; k < NCH; k++)
            if (wr[k]) mem_q[k][wr_ptr_q[k]] <= rx_data_i[8*k +: 8];
    end

    always_ff @(posedge clk_200 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            ch_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            ch_q <= ch_d;
        end
    end

    // DONE waits for start_n to rise so a held button cannot retrigger.
    always_comb begin
        state_d = IDLE;
        cnt_d = '0;
        ch_d = ch_q;
        case (state_q)
            IDLE: if (!start_n_i) begin
                state_d = RUN;
                ch_d = ({1'b0, run_ch_i} < NCH4) ? run_ch_i : 3'd0;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                state_d = ((run_len_i != '0) ? (cnt_q == run_len_i - 1'b1) : start_n_i) ? DONE : RUN;
            end
            DONE: state_d = start_n_i ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = state_q == RUN;
        mode_o = '0;
        for (int k = 0; k < NCH; k++)
            mode_o[2*k +: 2] = (busy_o && ch_q == 3'(k)) ? 2'b10 : 2'b01;
    end

    assign fill_o = fill_q;
    assign ovf_o = ovf_q;
    assign rd_data_o = rd_data_q;
    assign rd_valid_o = rd_valid_q;
endmodule

// File: tb/tb_eth_multi_capture_ctrl.sv
// tb_eth_multi_capture_ctrl: directed stimulus checked every cycle against a queue-based model plus literal expectations.
module tb_eth_multi_capture_ctrl;
    localparam int NCH = 2, AW = 3, SYNC = 2, CW = 32, DEPTH = 8;

    logic                  clk_200 = 1'b0;
    logic                  reset_n = 1'b0;
    logic [NCH-1:0]        rx_toggle_i, clr_i, ovf_o;
    logic [8*NCH-1:0]      rx_data_i;
    logic [2:0]            rd_ch_i, run_ch_i;
    logic                  rd_en_i, rd_valid_o, start_n_i, busy_o;
    logic [7:0]            rd_data_o;
    logic [(AW+1)*NCH-1:0] fill_o, ef;
    logic [CW-1:0]         run_len_i;
    logic [2*NCH-1:0]      mode_o, em;

    eth_multi_capture_ctrl #(.NCH(NCH), .AW(AW), .SYNC(SYNC), .CW(CW)) dut (
        .clk_200(clk_200), .reset_n(reset_n), .rx_toggle_i(rx_toggle_i), .rx_data_i(rx_data_i),
        .clr_i(clr_i), .rd_ch_i(rd_ch_i), .rd_en_i(rd_en_i), .rd_data_o(rd_data_o),
        .rd_valid_o(rd_valid_o), .fill_o(fill_o), .ovf_o(ovf_o), .start_n_i(start_n_i),
        .run_ch_i(run_ch_i), .run_len_i(run_len_i), .mode_o(mode_o), .busy_o(busy_o)
    );

    always #5 clk_200 = ~clk_200;

    int total = 0, bad = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: byte queues per channel, toggle samples delayed by SYNC+1 edges, countdown run timer.
    logic [7:0]     mq [NCH][$];
    logic [NCH-1:0] ts [SYNC+2];
    logic [NCH-1:0] m_ovf, m_ev;
    logic           m_rdv;
    logic [7:0]     m_rdd;
    bit             m_run, m_done;
    logic [2:0]     m_ch;
    longint         m_left;
    int             mc;

    always @(posedge clk_200 or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NCH; k++) mq[k].delete();
            for (int i = 0; i < SYNC + 2; i++) ts[i] = '0;
            m_ovf = '0; m_rdv = 0; m_rdd = '0;
            m_run = 0; m_done = 0; m_ch = '0; m_left = 0;
        end else begin
            for (int i = SYNC + 1; i > 0; i--) ts[i] = ts[i-1];
            ts[0] = rx_toggle_i;
            m_ev = ts[SYNC] ^ ts[SYNC+1];
            m_rdv = 0;
            for (int k = 0; k < NCH; k++)
                if (clr_i[k]) begin
                    mq[k].delete();
                    m_ovf[k] = 0;
                end
            mc = int'(rd_ch_i);
            if (rd_en_i && mc < NCH && !clr_i[mc] && mq[mc].size() > 0) begin
                m_rdd = mq[mc].pop_front();
                m_rdv = 1;
            end
            for (int k = 0; k < NCH; k++)
                if (m_ev[k] && !clr_i[k]) begin
                    if (mq[k].size() < DEPTH) mq[k].push_back(rx_data_i[8*k +: 8]);
                    else m_ovf[k] = 1;
                end
            if (m_run) begin
                if (m_left == 1 || (m_left == 0 && start_n_i)) begin
                    m_run = 0;
                    m_done = 1;
                end else if (m_left > 1) m_left--;
            end else if (m_done) begin
                if (start_n_i) m_done = 0;
            end else if (!start_n_i) begin
                m_run = 1;
                m_ch = (int'(run_ch_i) < NCH) ? run_ch_i : 3'd0;
                m_left = longint'(run_len_i);
            end
        end
    end

    always @(negedge clk_200) begin
        if (chk_en) begin
            ef = '0;
            em = '0;
            for (int k = 0; k < NCH; k++) begin
                ef[(AW+1)*k +: AW+1] = (AW+1)'(mq[k].size());
                em[2*k +: 2] = (m_run && m_ch == 3'(k)) ? 2'b10 : 2'b01;
            end
            check("m_fill", 32'(fill_o), 32'(ef));
            check("m_ovf", 32'(ovf_o), 32'(m_ovf));
            check("m_rd_valid", 32'(rd_valid_o), 32'(m_rdv));
            check("m_rd_data", 32'(rd_data_o), 32'(m_rdd));
            check("m_mode", 32'(mode_o), 32'(em));
            check("m_busy", 32'(busy_o), 32'(m_run));
        end
    end

    task automatic tog(input int k, input logic [7:0] b);
        @(negedge clk_200);
        rx_data_i[8*k +: 8] = b;
        rx_toggle_i[k] = ~rx_toggle_i[k];
    endtask

    task automatic do_rd(input logic [2:0] ch, output logic v, output logic [7:0] d);
        @(negedge clk_200);
        rd_ch_i = ch;
        rd_en_i = 1;
        @(negedge clk_200);
        rd_en_i = 0;
        v = rd_valid_o;
        d = rd_data_o;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic v;
        logic [7:0] d;
        rx_toggle_i = '0; rx_data_i = '0; clr_i = '0; rd_ch_i = '0; rd_en_i = 0;
        start_n_i = 1; run_ch_i = '0; run_len_i = '0;
        repeat (3) @(negedge clk_200);
        reset_n = 1;
        chk_en = 1;
        check("rst_fill", 32'(fill_o), 32'h0);
        check("rst_ovf", 32'(ovf_o), 32'h0);
        check("rst_mode", 32'(mode_o), 32'h5);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_rd_valid", 32'(rd_valid_o), 32'h0);
        check("rst_rd_data", 32'(rd_data_o), 32'h0);

        // Five bytes on ch0, fill steps SYNC+1 edges after each toggle.
        for (int i = 0; i < 5; i++) begin
            tog(0, 8'(8'h11 + i));
            repeat (2) @(negedge clk_200);
            check("lat_before", 32'(fill_o[3:0]), 32'(i));
            @(negedge clk_200);
            check("lat_after", 32'(fill_o[3:0]), 32'(i + 1));
            repeat (3) @(negedge clk_200);
        end
        check("ch1_idle_fill", 32'(fill_o[7:4]), 32'h0);
        for (int i = 0; i < 5; i++) begin
            do_rd(3'd0, v, d);
            check("rd1_valid", 32'(v), 32'h1);
            check("rd1_data", 32'(d), 32'(8'h11 + i));
        end

        // Overflow on ch1 with depth 8.
        for (int i = 0; i < 10; i++) begin
            tog(1, 8'(i + 1));
            repeat (5) @(negedge clk_200);
        end
        check("ovf_fill", 32'(fill_o[7:4]), 32'h8);
        check("ovf_flag", 32'(ovf_o[1]), 32'h1);
        for (int i = 0; i < 8; i++) begin
            do_rd(3'd1, v, d);
            check("ovf_rd_data", 32'(d), 32'(i + 1));
        end
        do_rd(3'd1, v, d);
        check("empty_valid", 32'(v), 32'h0);
        check("empty_hold", 32'(d), 32'h8);
        do_rd(3'd5, v, d);
        check("badch_valid", 32'(v), 32'h0);
        @(negedge clk_200); clr_i = 2'b10;
        @(negedge clk_200); clr_i = '0;
        check("clr_fill", 32'(fill_o[7:4]), 32'h0);
        check("clr_ovf", 32'(ovf_o[1]), 32'h0);

        // Write into a full FIFO on the same edge as a read of it.
        for (int i = 0; i < 8; i++) begin
            tog(1, 8'(8'h30 + i));
            repeat (5) @(negedge clk_200);
        end
        tog(1, 8'h40);
        @(negedge clk_200);
        @(negedge clk_200); rd_ch_i = 3'd1; rd_en_i = 1;
        @(negedge clk_200); rd_en_i = 0;
        check("fullrw_valid", 32'(rd_valid_o), 32'h1);
        check("fullrw_data", 32'(rd_data_o), 32'h30);
        check("fullrw_fill", 32'(fill_o[7:4]), 32'h8);
        check("fullrw_ovf", 32'(ovf_o[1]), 32'h0);
        @(negedge clk_200); clr_i = 2'b11;
        @(negedge clk_200); clr_i = '0;

        // Same-cycle write and read on ch0 at fill 3.
        for (int i = 0; i < 3; i++) begin
            tog(0, 8'(8'hA0 + i));
            repeat (5) @(negedge clk_200);
        end
        tog(0, 8'hA3);
        @(negedge clk_200);
        @(negedge clk_200); rd_ch_i = 3'd0; rd_en_i = 1;
        @(negedge clk_200); rd_en_i = 0;
        check("rw_valid", 32'(rd_valid_o), 32'h1);
        check("rw_data", 32'(rd_data_o), 32'hA0);
        check("rw_fill", 32'(fill_o[3:0]), 32'h3);
        for (int i = 1; i < 4; i++) begin
            do_rd(3'd0, v, d);
            check("rw_drain", 32'(d), 32'(8'hA0 + i));
        end
        do_rd(3'd0, v, d);
        check("rw_empty_valid", 32'(v), 32'h0);
        check("rw_empty_hold", 32'(d), 32'hA3);

        // Both channels toggled together.
        @(negedge clk_200);
        rx_data_i = 16'h6655;
        rx_toggle_i = ~rx_toggle_i;
        repeat (3) @(negedge clk_200);
        check("dual_fill", 32'(fill_o), 32'h11);
        do_rd(3'd0, v, d);
        check("dual_rd0", 32'(d), 32'h55);
        do_rd(3'd1, v, d);
        check("dual_rd1", 32'(d), 32'h66);

        // Timed run on ch1 for 4 cycles, held start keeps DONE.
        run_ch_i = 3'd1; run_len_i = 4;
        @(negedge clk_200); start_n_i = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_200);
            check("run4_mode", 32'(mode_o), 32'h9);
            check("run4_busy", 32'(busy_o), 32'h1);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_200);
            check("done_mode", 32'(mode_o), 32'h5);
            check("done_busy", 32'(busy_o), 32'h0);
        end
        start_n_i = 1;
        repeat (3) @(negedge clk_200);
        check("idle_mode", 32'(mode_o), 32'h5);

        // Out-of-range run_ch falls back to ch0.
        run_ch_i = 3'd5; run_len_i = 2;
        @(negedge clk_200); start_n_i = 0;
        @(negedge clk_200); check("ch0_run_a", 32'(mode_o), 32'h6);
        @(negedge clk_200); check("ch0_run_b", 32'(mode_o), 32'h6);
        @(negedge clk_200); check("ch0_done", 32'(mode_o), 32'h5);
        start_n_i = 1;
        repeat (2) @(negedge clk_200);

        // Open-ended run, then reset in the middle of a run.
        run_ch_i = 3'd1; run_len_i = 0;
        @(negedge clk_200); start_n_i = 0;
        repeat (20) @(negedge clk_200);
        check("open_busy", 32'(busy_o), 32'h1);
        start_n_i = 1;
        @(negedge clk_200); check("open_done", 32'(busy_o), 32'h0);
        @(negedge clk_200);
        start_n_i = 0;
        repeat (3) @(negedge clk_200);
        check("pre_rst_busy", 32'(busy_o), 32'h1);
        #2 reset_n = 0;
        #1;
        check("async_rst_busy", 32'(busy_o), 32'h0);
        check("async_rst_mode", 32'(mode_o), 32'h5);
        check("async_rst_fill", 32'(fill_o), 32'h0);
        start_n_i = 1;
        repeat (2) @(negedge clk_200);
        reset_n = 1;
        repeat (6) @(negedge clk_200);
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
